// File: rtl/controller.sv
// MIPS instruction decoder: combinational write-enable/destination/class outputs,
// plus a one-cycle registered copy of we/a3 used for write-back hazard tracking.
module controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        we,
    output logic [4:0]  a3,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_md,
    output logic        ri,
    output logic        we_q,
    output logic [4:0]  a3_q
);

    typedef enum logic [2:0] {
        C_NONE, C_WR, C_LOAD, C_STORE, C_BRANCH, C_MD, C_RI
    } cls_e;

    typedef enum logic [1:0] {D_RD, D_RT, D_RA} dst_e;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    cls_e       cls;
    dst_e       dst;
    logic [4:0] a3_d;
    logic       we_d;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];

    // NOTE: cls and dst get defaults before the case so no path leaves them unassigned (no latch).
    always_comb begin
        cls = C_RI;
        dst = D_RD;
        if (instr == INSTR_NOP) begin
            cls = C_NONE;
        end else begin
            unique case (opcode)
                6'b000000: begin
                    dst = D_RD;
                    case (funct)
                        6'b100000, 6'b100010, 6'b100100, 6'b100101,
                        6'b101010, 6'b101011, 6'b010000, 6'b010010: cls = C_WR;
                        6'b001000, 6'b001100:                       cls = C_NONE;
                        6'b011000, 6'b011001, 6'b011010, 6'b011011,
                        6'b010001, 6'b010011:                       cls = C_MD;
                        default:                                    cls = C_RI;
                    endcase
                end
                6'b001000, 6'b001100, 6'b001101, 6'b001111: begin
                    cls = C_WR;
                    dst = D_RT;
                end
                6'b100011, 6'b100001, 6'b100000: begin
                    cls = C_LOAD;
                    dst = D_RT;
                end
                6'b101011, 6'b101001, 6'b101000: cls = C_STORE;
                6'b000100, 6'b000101:            cls = C_BRANCH;
                6'b000011: begin
                    cls = C_WR;
                    dst = D_RA;
                end
                6'b010000: begin
                    // eret is matched on the full word before the rs field is considered.
                    if (instr == INSTR_ERET) begin
                        cls = C_NONE;
                    end else if (rs == 5'b00000) begin
                        cls = C_WR;
                        dst = D_RT;
                    end else if (rs == 5'b00100) begin
                        cls = C_NONE;
                    end else begin
                        cls = C_RI;
                    end
                end
                default: cls = C_RI;
            endcase
        end
    end

    always_comb begin
        we_d = (cls == C_WR) || (cls == C_LOAD);
        a3_d = 5'd0;
        if (we_d) begin
            unique case (dst)
                D_RD:    a3_d = rd;
                D_RT:    a3_d = rt;
                D_RA:    a3_d = 5'd31;
                default: a3_d = 5'd0;
            endcase
        end
    end

    assign we        = we_d;
    assign a3        = a3_d;
    assign is_load   = (cls == C_LOAD);
    assign is_store  = (cls == C_STORE);
    assign is_branch = (cls == C_BRANCH);
    assign is_md     = (cls == C_MD);
    assign ri        = (cls == C_RI);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q <= 1'b0;
            a3_q <= 5'd0;
        end else begin
            we_q <= we_d;
            a3_q <= a3_d;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: table-driven decode model checked every
// negedge, plus directed vectors with hand-computed expectations.
module tb_controller;

    typedef struct packed {
        logic       ri;
        logic       md;
        logic       br;
        logic       st;
        logic       ld;
        logic       we;
        logic [4:0] a3;
    } dec_t;

    typedef struct {
        logic [31:0] w;
        dec_t        exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        we, is_load, is_store, is_branch, is_md, ri, we_q;
    logic [4:0]  a3, a3_q;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       m_we_q;
    logic [4:0] m_a3_q;

    controller dut (
        .clk(clk), .reset(reset), .instr(instr),
        .we(we), .a3(a3), .is_load(is_load), .is_store(is_store),
        .is_branch(is_branch), .is_md(is_md), .ri(ri),
        .we_q(we_q), .a3_q(a3_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] R_WR [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h10, 6'h12};
    localparam logic [5:0] R_NW [2] = '{6'h08, 6'h0c};
    localparam logic [5:0] R_MD [6] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13};
    localparam logic [5:0] I_WR [4] = '{6'h08, 6'h0c, 6'h0d, 6'h0f};
    localparam logic [5:0] I_LD [3] = '{6'h23, 6'h21, 6'h20};
    localparam logic [5:0] I_ST [3] = '{6'h2b, 6'h29, 6'h28};
    localparam logic [5:0] I_BR [2] = '{6'h04, 6'h05};

    // Reference decode built from membership in the instruction tables.
    function automatic dec_t model(input logic [31:0] w);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic       known;
        d     = '0;
        op    = w[31:26];
        fn    = w[5:0];
        known = 1'b0;
        if (w == 32'h0) return d;
        if (op == 6'h00) begin
            foreach (R_WR[i]) if (fn == R_WR[i]) begin known = 1; d.we = 1; d.a3 = w[15:11]; end
            foreach (R_NW[i]) if (fn == R_NW[i]) known = 1;
            foreach (R_MD[i]) if (fn == R_MD[i]) begin known = 1; d.md = 1; end
        end else if (op == 6'h03) begin
            known = 1; d.we = 1; d.a3 = 5'd31;
        end else if (op == 6'h10) begin
            if (w == 32'h4200_0018)       known = 1;
            else if (w[25:21] == 5'd0)    begin known = 1; d.we = 1; d.a3 = w[20:16]; end
            else if (w[25:21] == 5'd4)    known = 1;
        end else begin
            foreach (I_WR[i]) if (op == I_WR[i]) begin known = 1; d.we = 1; d.a3 = w[20:16]; end
            foreach (I_LD[i]) if (op == I_LD[i]) begin known = 1; d.we = 1; d.ld = 1; d.a3 = w[20:16]; end
            foreach (I_ST[i]) if (op == I_ST[i]) begin known = 1; d.st = 1; end
            foreach (I_BR[i]) if (op == I_BR[i]) begin known = 1; d.br = 1; end
        end
        if (!known) begin
            d    = '0;
            d.ri = 1'b1;
        end
        return d;
    endfunction

    function automatic dec_t dut_dec();
        dec_t d;
        d.ri = ri; d.md = is_md; d.br = is_branch; d.st = is_store;
        d.ld = is_load; d.we = we; d.a3 = a3;
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (instr=0x%08h)", name, act, exp, instr);
        end
    endtask

    // Registered write tracker reference: previous-cycle decode, cleared while reset is low.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_we_q <= 1'b0;
            m_a3_q <= 5'd0;
        end else begin
            m_we_q <= model(instr).we;
            m_a3_q <= model(instr).a3;
        end
    end

    always @(negedge clk) begin
        check("model_decode", 32'(dut_dec()), 32'(model(instr)));
        check("model_we_q",   32'(we_q), 32'(m_we_q));
        check("model_a3_q",   32'(a3_q), 32'(m_a3_q));
    end

    // {ri, md, br, st, ld, we, a3}
    vec_t vecs[] = '{
        '{32'h012A_4020, '{0,0,0,0,0,1,5'd8}},
        '{32'h8D0B_0004, '{0,0,0,0,1,1,5'd11}},
        '{32'hAD0B_0004, '{0,0,0,1,0,0,5'd0}},
        '{32'h0C00_0010, '{0,0,0,0,0,1,5'd31}},
        '{32'h1109_0003, '{0,0,1,0,0,0,5'd0}},
        '{32'h4008_6000, '{0,0,0,0,0,1,5'd8}},
        '{32'h4200_0018, '{0,0,0,0,0,0,5'd0}},
        '{32'hFC00_0000, '{1,0,0,0,0,0,5'd0}},
        '{32'h0000_0000, '{0,0,0,0,0,0,5'd0}},
        '{32'h4088_6000, '{0,0,0,0,0,0,5'd0}},
        '{32'h0109_0018, '{0,1,0,0,0,0,5'd0}},
        '{32'h03E0_0008, '{0,0,0,0,0,0,5'd0}},
        '{32'h0000_000C, '{0,0,0,0,0,0,5'd0}},
        '{32'h0000_0001, '{1,0,0,0,0,0,5'd0}},
        '{32'h0800_0010, '{1,0,0,0,0,0,5'd0}},
        '{32'h3C01_ABCD, '{0,0,0,0,0,1,5'd1}},
        '{32'h2000_0005, '{0,0,0,0,0,1,5'd0}},
        '{32'h0000_4010, '{0,0,0,0,0,1,5'd8}},
        '{32'h4200_0019, '{1,0,0,0,0,0,5'd0}},
        '{32'h40A0_0000, '{1,0,0,0,0,0,5'd0}}
    };

    initial begin
        reset = 1'b0;
        instr = 32'h012A_4020;
        repeat (2) @(posedge clk);
        #1;
        check("reset_we_q", 32'(we_q), 32'd0);
        check("reset_a3_q", 32'(a3_q), 32'd0);
        check("reset_comb_we", 32'(we), 32'd1);
        check("reset_comb_a3", 32'(a3), 32'd8);
        reset = 1'b1;

        // Directed vectors: literal decode, then the captured copy one edge later.
        foreach (vecs[i]) begin
            instr = vecs[i].w;
            #1;
            check($sformatf("vec%0d_decode", i), 32'(dut_dec()), 32'(vecs[i].exp));
            @(posedge clk); #1;
            check($sformatf("vec%0d_we_q", i), 32'(we_q), 32'(vecs[i].exp.we));
            check($sformatf("vec%0d_a3_q", i), 32'(a3_q), 32'(vecs[i].exp.a3));
        end

        // Mid-cycle asynchronous reset with add $8 captured.
        instr = 32'h012A_4020;
        @(posedge clk); #1;
        check("add_we_q", 32'(we_q), 32'd1);
        check("add_a3_q", 32'(a3_q), 32'd8);
        #2 reset = 1'b0;
        #1;
        check("async_we_q", 32'(we_q), 32'd0);
        check("async_a3_q", 32'(a3_q), 32'd0);
        check("async_comb_a3", 32'(a3), 32'd8);
        @(posedge clk); #1;
        check("hold_we_q", 32'(we_q), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("release_we_q", 32'(we_q), 32'd1);
        check("release_a3_q", 32'(a3_q), 32'd8);
        instr = 32'h0000_0000;
        @(posedge clk); #1;
        check("nop_we_q", 32'(we_q), 32'd0);
        check("nop_a3_q", 32'(a3_q), 32'd0);

        // Sweeps checked by the model compare process every negedge.
        for (int op = 0; op < 64; op++) begin
            instr = {6'(op), 26'h1A5_4321};
            @(posedge clk); #1;
        end
        for (int fn = 0; fn < 64; fn++) begin
            instr = {6'h00, 5'd3, 5'd7, 5'd19, 5'd0, 6'(fn)};
            @(posedge clk); #1;
        end
        for (int r = 0; r < 32; r++) begin
            instr = {6'h10, 5'(r), 5'd14, 5'd12, 11'h000};
            @(posedge clk); #1;
        end
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 clk  input  1  rising-edge clock for the registered write-back tracker.
REQ-002 reset  input  1  asynchronous, active-low; 0 clears all registered outputs immediately, regardless of clk.
REQ-003 instr  input  32  MIPS instruction word to decode; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
REQ-004 we  output  1  combinational GPR write enable for instr.
REQ-005 a3  output  5  combinational GPR destination index; 0 when we=0.
REQ-006 is_load  output  1  combinational; 1 for lw/lh/lb.
REQ-007 is_store  output  1  combinational; 1 for sw/sh/sb.
REQ-008 is_branch  output  1  combinational; 1 for beq/bne.
REQ-009 is_md  output  1  combinational; 1 for mult/multu/div/divu/mthi/mtlo.
REQ-010 ri  output  1  combinational; 1 for any word not listed in REQ-012..REQ-016.
REQ-011 we_q, a3_q  output  1, 5  we and a3 registered one cycle (previous-stage write tracker).

Function
REQ-012 R-type (opcode 000000) SHALL decode funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sltu 101011, mfhi 010000, mflo 010010 -> we=1, a3=rd; jr 001000, mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011, syscall 001100 -> we=0.
REQ-013 I-type: addi 001000, andi 001100, ori 001101, lui 001111, lw 100011, lh 100001, lb 100000 -> we=1, a3=rt; sw 101011, sh 101001, sb 101000, beq 000100, bne 000101 -> we=0.
REQ-014 jal (opcode 000011) SHALL give we=1, a3=31.
REQ-015 COP0 (opcode 010000): rs=00000 mfc0 -> we=1, a3=rt; rs=00100 mtc0 -> we=0; instr=0x42000018 eret -> we=0; other COP0 encodings -> ri=1.
REQ-016 instr=0x00000000 (nop) SHALL give all outputs 0, ri=0.
REQ-017 Any instruction with ri=1 SHALL force we=0, a3=0, and is_* = 0.
REQ-018 If decoded a3=0, we SHALL still follow the table; consumers treat register 0 as constant zero.
REQ-019 Decode outputs SHALL be purely combinational, settling within the same cycle instr changes; no dependence on clk or reset.
REQ-020 On each rising clk edge with reset=1: we_q <= we, a3_q <= a3.
REQ-021 Exactly one of {we-type, is_load, is_store, is_branch, is_md} classes is not required; is_load implies we=1; is_store, is_branch, is_md imply we=0.

Reset
REQ-022 reset=0 SHALL asynchronously set we_q=0, a3_q=0 and hold them while asserted.
REQ-023 Combinational outputs SHALL remain valid during reset.
REQ-024 First rising edge after reset deasserts SHALL capture current we/a3.

Verification
REQ-025 instr=0x012A4020 (add $8,$9,$10) -> we=1, a3=8, ri=0, is_*=0.
REQ-026 instr=0x8D0B0004 (lw $11,4($8)) -> we=1, a3=11, is_load=1; instr=0xAD0B0004 (sw) -> we=0, a3=0, is_store=1.
REQ-027 instr=0x0C000010 (jal) -> we=1, a3=31; instr=0x11090003 (beq) -> we=0, is_branch=1.
REQ-028 instr=0x40086000 (mfc0 $8,$12) -> we=1, a3=8; instr=0x42000018 -> we=0, ri=0; instr=0xFC000000 -> ri=1, we=0.
REQ-029 add $8 presented, clock edge -> we_q=1, a3_q=8; reset pulled low mid-cycle -> we_q=0, a3_q=0 before next edge.
REQ-030 instr=0x00000000 -> all outputs 0 including ri; after one edge we_q=0.
